// File: rtl/error_recovery_acc_if.sv
// error_recovery_acc_if: beat input and group result handshake bundle
interface error_recovery_acc_if #(
  parameter int N       = 16,
  parameter int OUT_LSB = 20
);
  localparam int OW  = 2*N - OUT_LSB;
  localparam int OFW = $clog2(2*N);
  logic           in_valid;
  logic           in_ready;
  logic [N-2:0]   in_vec;
  logic [OFW-1:0] in_off;
  logic           in_last;
  logic           mode;
  logic           out_valid;
  logic           out_ready;
  logic [OW-1:0]  out_err;
  logic           out_ovf;
  modport master (
    output in_valid, in_vec, in_off, in_last, mode, out_ready,
    input  in_ready, out_valid, out_err, out_ovf
  );
  modport slave (
    input  in_valid, in_vec, in_off, in_last, mode, out_ready,
    output in_ready, out_valid, out_err, out_ovf
  );
endinterface

// File: rtl/error_recovery_acc.sv
// error_recovery_acc: accumulates shifted error vectors per group (OR or ADD) and holds the result until taken
module error_recovery_acc #(
  parameter int N       = 16,
  parameter int OUT_LSB = 20
) (
  input logic                 clk,
  input logic                 rst,
  error_recovery_acc_if.slave bus_io
);
  localparam int W  = 2*N;
  localparam int CW = $clog2(N);
  typedef enum logic {ACC, DONE} state_t;
  state_t          state_q, state_d;
  logic [W-1:0]    acc_q, acc_d;
  logic            ovf_q, ovf_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mode_q, mode_d;
  logic [3*N-1:0]  sh;
  logic [W-1:0]    base;
  logic [W:0]      sum;
  logic            first, m, base_ovf, close;
  // the first beat of a group ignores whatever the registers still hold
  assign first    = cnt_q == '0;
  assign m        = first ? bus_io.mode : mode_q;
  assign base     = first ? '0 : acc_q;
  assign base_ovf = first ? 1'b0 : ovf_q;
  assign sh       = {{(W+1){1'b0}}, bus_io.in_vec} << bus_io.in_off;
  assign sum      = {1'b0, base} + {1'b0, sh[W-1:0]};
  assign close    = bus_io.in_last || cnt_q == CW'(N-2);
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    if (state_q == ACC && bus_io.in_valid) begin
      acc_d   = m ? sum[W-1:0] : base | sh[W-1:0];
      ovf_d   = base_ovf | (|sh[3*N-1:W]) | (m & sum[W]);
      cnt_d   = cnt_q + CW'(1);
      mode_d  = m;
      state_d = close ? DONE : ACC;
    end else if (state_q == DONE && bus_io.out_ready) begin
      state_d = ACC;
      acc_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end
  assign bus_io.in_ready  = state_q == ACC && !rst;
  assign bus_io.out_valid = state_q == DONE && !rst;
  assign bus_io.out_err   = rst ? '0 : acc_q[W-1:OUT_LSB];
  assign bus_io.out_ovf   = !rst && ovf_q;
endmodule

// File: tb/tb_error_recovery_acc.sv
// tb_error_recovery_acc: directed and random groups against a transaction-level model
module tb_error_recovery_acc;
  localparam int N       = 16;
  localparam int OUT_LSB = 20;
  localparam int W       = 2*N;
  logic clk = 0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [N-2:0] g_vec[32];
  int           g_off[32];
  bit           g_mode[32];
  bit           g_last[32];
  error_recovery_acc_if #(.N(N), .OUT_LSB(OUT_LSB)) ifc ();
  error_recovery_acc #(.N(N), .OUT_LSB(OUT_LSB)) dut (.clk(clk), .rst(rst), .bus_io(ifc.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // group result straight from the combining rules, in wide integer arithmetic
  function automatic void model(input int n, output int close, output logic [63:0] err, output bit ovf);
    longint unsigned a = 0, v, t;
    bit gm = g_mode[0];
    ovf   = 0;
    close = n - 1;
    for (int i = 0; i < n; i++) begin
      v = longint'(g_vec[i]) << g_off[i];
      if (gm) begin
        t   = a + v;
        ovf = ovf | ((t >> W) != 0);
        a   = t % (64'd1 << W);
      end else begin
        ovf = ovf | ((v >> W) != 0);
        a   = (a | v) % (64'd1 << W);
      end
      if (g_last[i] || i + 1 == N - 1) begin
        close = i;
        break;
      end
    end
    err = a >> OUT_LSB;
  endfunction
  task automatic put_beat(input int i);
    ifc.in_valid = 1;
    ifc.in_vec   = g_vec[i];
    ifc.in_off   = 5'(g_off[i]);
    ifc.mode     = g_mode[i];
    ifc.in_last  = g_last[i];
  endtask
  task automatic drive_group(input int n, input int hold, input bit gaps);
    int close;
    logic [63:0] e_err;
    bit e_ovf;
    model(n, close, e_err, e_ovf);
    for (int i = 0; i <= close; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        ifc.in_valid = 0;
        ifc.in_vec   = (N-1)'($urandom);
        ifc.mode     = 1'($urandom);
        @(posedge clk); #1;
        chk("idle_out_valid", ifc.out_valid, 0);
      end
      put_beat(i);
      chk("beat_in_ready", ifc.in_ready, 1);
      @(posedge clk); #1;
      chk(i == close ? "close_out_valid" : "mid_out_valid", ifc.out_valid, i == close);
    end
    ifc.in_valid = 0;
    chk("out_err", ifc.out_err, e_err);
    chk("out_ovf", ifc.out_ovf, e_ovf);
    for (int h = 0; h < hold; h++) begin
      ifc.in_valid = 1;
      ifc.in_vec   = (N-1)'($urandom);
      ifc.in_off   = 5'($urandom);
      ifc.in_last  = 1'($urandom);
      ifc.out_ready = 0;
      @(posedge clk); #1;
      chk("hold_out_valid", ifc.out_valid, 1);
      chk("hold_in_ready", ifc.in_ready, 0);
      chk("hold_out_err", ifc.out_err, e_err);
      chk("hold_out_ovf", ifc.out_ovf, e_ovf);
    end
    ifc.in_valid  = 0;
    ifc.out_ready = 1;
    @(posedge clk); #1;
    ifc.out_ready = 0;
    chk("release_out_valid", ifc.out_valid, 0);
    chk("release_in_ready", ifc.in_ready, 1);
  endtask
  initial begin
    rst = 1;
    ifc.in_valid = 0; ifc.in_vec = '0; ifc.in_off = '0; ifc.in_last = 0;
    ifc.mode = 0; ifc.out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", ifc.in_ready, 0);
    chk("rst_out_valid", ifc.out_valid, 0);
    chk("rst_out_err", ifc.out_err, 0);
    chk("rst_out_ovf", ifc.out_ovf, 0);
    rst = 0;
    #1;
    chk("post_rst_in_ready", ifc.in_ready, 1);
    // OR mode 0x7FFF at offsets 3..17 fills bits 3..31
    for (int i = 0; i < 15; i++) begin
      g_vec[i] = 15'h7FFF; g_off[i] = 3 + i; g_mode[i] = 0; g_last[i] = (i == 14);
    end
    drive_group(15, 0, 0);
    // ADD mode bit 31 twice wraps to zero with overflow
    for (int i = 0; i < 2; i++) begin
      g_vec[i] = 15'h4000; g_off[i] = 17; g_mode[i] = 1; g_last[i] = (i == 1);
    end
    drive_group(2, 0, 0);
    g_vec[0] = 15'h0001; g_off[0] = 19; g_mode[0] = 0; g_last[0] = 1;
    drive_group(1, 0, 0);
    g_vec[0] = 15'h0001; g_off[0] = 20; g_mode[0] = 0; g_last[0] = 1;
    drive_group(1, 3, 0);
    // no in_last at all: forced close after N-1 beats, extra beat held off during hold
    for (int i = 0; i < 16; i++) begin
      g_vec[i] = (N-1)'($urandom); g_off[i] = $urandom_range(0, 31);
      g_mode[i] = 1'($urandom); g_last[i] = 0;
    end
    drive_group(15, 2, 0);
    g_vec[0] = g_vec[15]; g_off[0] = g_off[15]; g_mode[0] = g_mode[15]; g_last[0] = 1;
    drive_group(1, 0, 0);
    // reset partway through a group
    for (int i = 0; i < 8; i++) begin
      g_vec[i] = (N-1)'($urandom); g_off[i] = $urandom_range(10, 31);
      g_mode[i] = (i == 0); g_last[i] = (i == 7);
    end
    for (int i = 0; i < 5; i++) begin
      put_beat(i);
      @(posedge clk); #1;
    end
    ifc.in_valid = 0;
    rst = 1;
    #1;
    chk("midrst_in_ready", ifc.in_ready, 0);
    chk("midrst_out_valid", ifc.out_valid, 0);
    @(posedge clk); #1;
    rst = 0;
    #1;
    chk("after_rst_out_valid", ifc.out_valid, 0);
    chk("after_rst_out_err", ifc.out_err, 0);
    chk("after_rst_out_ovf", ifc.out_ovf, 0);
    drive_group(8, 0, 0);
    // random groups with mid-group mode flips, idle gaps and output stalls
    for (int g = 0; g < 60; g++) begin
      int n = $urandom_range(1, 15);
      for (int i = 0; i < n; i++) begin
        g_vec[i]  = (N-1)'($urandom);
        g_off[i]  = $urandom_range(0, 31);
        g_mode[i] = 1'($urandom);
        g_last[i] = (i == n - 1) || ($urandom_range(0, 9) == 0);
      end
      drive_group(n, $urandom_range(0, 3), 1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/error_recovery_acc.md
ERROR_RECOVERY_ACC -- requirements
Module: error_recovery_acc

Interface
REQ-001 Parameter N, default 16: multiplier operand width; legal range 4..32.
REQ-002 Parameter OUT_LSB, default 20: lowest accumulator bit presented on out_err; legal range 0..2N-1.
REQ-003 Parameter OW, derived as 2N-OUT_LSB: out_err width.
REQ-004 Port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 Port rst  in  1  synchronous, active-high reset.
REQ-006 Port in_valid  in  1  error-vector beat present.
REQ-007 Port in_ready  out  1  block accepts a beat this cycle.
REQ-008 Port in_vec  in  N-1  partial error vector (row-pair error term).
REQ-009 Port in_off  in  clog2(2N)  bit offset at which in_vec is placed in the 2N-bit accumulator.
REQ-010 Port in_last  in  1  final beat of current group.
REQ-011 Port mode  in  1  0 = OR combine (approximate recovery), 1 = ADD combine (exact error sum).
REQ-012 Port out_valid  out  1  group result available.
REQ-013 Port out_ready  in  1  consumer accepts result.
REQ-014 Port out_err  out  OW  accumulator bits [2N-1:OUT_LSB].
REQ-015 Port out_ovf  out  1  sticky: data lost above bit 2N-1 during the group.

Function
REQ-016 Beat accepted when in_valid and in_ready both high in the same cycle.
REQ-017 State ACC: in_ready=1, out_valid=0; state DONE: in_ready=0, out_valid=1.
REQ-018 Group mode latched on the first accepted beat of a group; mode changes during the rest of the group ignored.
REQ-019 OR mode: acc <= acc | (in_vec << in_off), truncated to 2N bits; any set bit shifted above bit 2N-1 sets ovf.
REQ-020 ADD mode: acc <= acc + (in_vec << in_off) modulo 2^2N; carry out of bit 2N-1 or any in_vec bit shifted above bit 2N-1 sets ovf.
REQ-021 First beat of a group combines against a zero accumulator and clear ovf (no stale data from the previous group).
REQ-022 Beat counter increments per accepted beat; group closes on accepted beat with in_last=1, or on the (N-1)th accepted beat regardless of in_last.
REQ-023 On group close: transition ACC->DONE; out_valid asserted the cycle after the closing beat, with the closing beat included in out_err.
REQ-024 DONE: out_err and out_ovf held stable until out_valid and out_ready both high.
REQ-025 On output handshake: DONE->ACC next cycle, accumulator, ovf, beat counter cleared; in_ready high that cycle.
REQ-026 No beat accepted in DONE; no same-cycle pass-through of a new beat while a result is held.
REQ-027 Throughput: one beat per cycle in ACC; minimum one bubble cycle between groups.
REQ-028 in_valid low in ACC: state unchanged, partial accumulation held indefinitely.

Reset
REQ-029 rst high at a clock edge: state=ACC, accumulator=0, ovf=0, beat counter=0, latched mode=0.
REQ-030 Reset outputs: in_ready=0 during reset cycle, 1 thereafter; out_valid=0; out_err=0; out_ovf=0.
REQ-031 Reset mid-group or in DONE discards partial/held result; no out_valid for that group.
REQ-032 rst has priority over any concurrent handshake.

Verification (N=16, OUT_LSB=20)
REQ-033 OR mode, 15 beats in_vec=0x7FFF at offsets 3..17, last on 15th -> out_err=0xFFF, out_ovf=0, out_valid one cycle after 15th beat.
REQ-034 ADD mode, two beats in_vec=0x4000 off=17 (bit 31 each), last on 2nd -> out_err=0x000, out_ovf=1.
REQ-035 OR mode, single beat in_vec=0x0001 off=19, last -> out_err=0x000, out_ovf=0; next group in_vec=0x0001 off=20 -> out_err=0x001 (no residue from prior group).
REQ-036 out_ready low 3 cycles after result -> out_err stable, in_ready=0 throughout, in_valid beats not consumed; result released on 4th cycle, in_ready=1 next cycle.
REQ-037 15 beats without in_last -> group force-closed after 15th beat; 16th beat held off until output handshake, then starts new group.
REQ-038 rst asserted after 5 beats of a group -> no out_valid; following full group produces result identical to reset-free run.
